// File: rtl/cpu_pkg.sv
// Shared processor constants: register-file geometry, named register indices
// and the write-counter ceiling.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_AT   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [15:0] WR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/reg_read_port.sv
// One register-file read port: forces index 0 to zero and, when enabled,
// forwards a same-cycle write to the reader before it reaches the array.
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_arrayData,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic w_isZero;
  logic w_bypassHit;

  // A write to index 0 is never committed, so it must never be forwarded either.
  assign w_isZero    = (i_raddr == ZERO_IDX);
  assign w_bypassHit = (BYPASS != 0) && i_we && (i_waddr != ZERO_IDX) && (i_waddr == i_raddr);

  assign o_rdata = w_isZero    ? '0 :
                   w_bypassHit ? i_wdata :
                                 i_arrayData;

endmodule

// File: rtl/reg_file32.sv
// 32 x 32-bit register file with two combinational read ports feeding the ALU,
// one write-back port, a raw debug read port and a saturating write counter.
module reg_file32
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_cnt
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Entry 0 is hard-wired to zero, so it has no storage.
  logic [DATA_W-1:0] r_mem [1:DEPTH-1];
  logic [15:0]       r_wrCnt;

  logic              w_commit;
  logic [DATA_W-1:0] w_rawA;
  logic [DATA_W-1:0] w_rawB;

  assign w_commit = we && (waddr != ZERO_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VAL;
      end
      r_wrCnt <= '0;
    end else if (w_commit) begin
      r_mem[waddr] <= wdata;
      if (r_wrCnt != WR_CNT_MAX) begin
        r_wrCnt <= r_wrCnt + 16'd1;
      end
    end
  end

  assign w_rawA   = (raddr_a  == ZERO_IDX) ? '0 : r_mem[raddr_a];
  assign w_rawB   = (raddr_b  == ZERO_IDX) ? '0 : r_mem[raddr_b];
  assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : r_mem[dbg_addr];
  assign wr_cnt   = r_wrCnt;

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_portA (
    .i_raddr     (raddr_a),
    .i_arrayData (w_rawA),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_rdata     (rdata_a)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_portB (
    .i_raddr     (raddr_b),
    .i_arrayData (w_rawB),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_rdata     (rdata_b)
  );

endmodule
